// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a serial one-bit-per-cycle shifter for SRL/SLL,
// valid/ready handshakes on both sides, and registered result/branch/jump/illegal flags.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               BranchTaken,
    output logic               JumpReg,
    output logic               Illegal
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_shreg, w_shifted, w_res, w_diff;
    logic [SHAMT_W-1:0]   r_cnt;
    logic                 r_left, w_accept, w_serial, w_br, w_jr, w_ill;

    assign in_ready  = (r_state == IDLE) || (r_state == DONE && out_ready);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    // A zero-amount shift needs no serial work and completes like any single-cycle op
    assign w_serial  = (ALUOperation == 4'b0101 || ALUOperation == 4'b0110) && shamt != '0;
    assign w_diff    = A - B;
    assign w_shifted = r_left ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = w_serial ? SHIFT : DONE;
        else if (r_state == SHIFT)
            w_next = (r_cnt == SHAMT_W'(1)) ? DONE : SHIFT;
        else if (r_state == DONE && out_ready)
            w_next = IDLE;
    end

    always_comb begin
        w_res = '0;
        w_br  = 1'b0;
        w_jr  = 1'b0;
        w_ill = 1'b0;
        case (ALUOperation)
            4'b0000: w_res = A & B;
            4'b0001: w_res = A | B;
            4'b0010: w_res = ~(A | B);
            4'b0011: w_res = A + B;
            4'b0100: w_res = w_diff;
            4'b0101: w_res = B;
            4'b0110: w_res = B;
            4'b0111: w_res = {B[15:0], {(WIDTH-16){1'b0}}};
            4'b1000: begin w_res = w_diff; w_br = (A == B); end
            4'b1001: begin w_res = w_diff; w_br = (A != B); end
            4'b1110: begin w_res = A; w_jr = 1'b1; end
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_left      <= 1'b0;
            ALUResult   <= '0;
            Zero        <= 1'b0;
            BranchTaken <= 1'b0;
            JumpReg     <= 1'b0;
            Illegal     <= 1'b0;
        end else if (w_accept && w_serial) begin
            r_shreg <= B;
            r_cnt   <= shamt;
            r_left  <= ALUOperation[1];
        end else if (w_accept) begin
            ALUResult   <= w_res;
            Zero        <= (w_res == '0);
            BranchTaken <= w_br;
            JumpReg     <= w_jr;
            Illegal     <= w_ill;
        end else if (r_state == SHIFT) begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
                ALUResult   <= w_shifted;
                Zero        <= (w_shifted == '0);
                BranchTaken <= 1'b0;
                JumpReg     <= 1'b0;
                Illegal     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized stimulus with a queue scoreboard checked by
// an independent monitor against a behavioural ALU model.
module tb_alu_exec_unit;
    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]  ALUOperation = '0;
    logic [31:0] A = '0, B = '0;
    logic [4:0]  shamt = '0;
    logic        in_ready, out_valid, Zero, BranchTaken, JumpReg, Illegal;
    logic [31:0] ALUResult;

    int checks = 0, errors = 0, cyc = 0;
    bit rnd_en = 1'b0;
    logic [35:0] q[$];

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOperation(ALUOperation), .A(A), .B(B), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
        .Zero(Zero), .BranchTaken(BranchTaken), .JumpReg(JumpReg), .Illegal(Illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {Illegal, JumpReg, BranchTaken, Zero, result}
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh);
        logic [31:0] r;
        logic br, jr, il;
        r = '0; br = 1'b0; jr = 1'b0; il = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = ~(a | b);
            4'd3:  r = a + b;
            4'd4:  r = a - b;
            4'd5:  r = b >> sh;
            4'd6:  r = b << sh;
            4'd7:  r = {b[15:0], 16'h0};
            4'd8:  begin r = a - b; br = (a == b); end
            4'd9:  begin r = a - b; br = (a != b); end
            4'd14: begin r = a; jr = 1'b1; end
            default: il = 1'b1;
        endcase
        return {il, jr, br, (r == 32'd0), r};
    endfunction

    initial forever begin
        @(negedge clk);
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", ALUResult);
            end else begin
                chk("scoreboard", {28'b0, Illegal, JumpReg, BranchTaken, Zero, ALUResult}, {28'b0, q.pop_front()});
            end
        end
    end

    // Called and returns at posedge+1; pushes the expected response on the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic acc;
        bit done;
        done = 1'b0;
        ALUOperation = op; A = a; B = b; shamt = sh; in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                q.push_back(model(op, a, b, sh));
                done = 1'b1;
            end
            #1;
            if (rnd_en) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept for op %h", op);
        end
    endtask

    task automatic wait_valid(output int lat, output int nrdy);
        lat = 0;
        nrdy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (!in_ready) nrdy++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
            if (rnd_en) out_ready = 1'($urandom_range(0, 1));
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int lat, nrdy, c0;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        logic [4:0]  rs;
        #3;
        chk("reset_outputs", {out_valid, ALUResult, Zero, BranchTaken, JumpReg, Illegal}, 64'd0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;

        send(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0);
        wait_valid(lat, nrdy);
        chk("add_latency", lat, 1);
        chk("add_zero", {Zero, ALUResult}, {1'b1, 32'd0});
        @(negedge clk);
        chk("add_then_idle", out_valid, 0);
        @(posedge clk) #1;

        send(4'd8, 32'h1234, 32'h1234, 5'd0);
        send(4'd9, 32'h1234, 32'h1234, 5'd0);
        send(4'd9, 32'd5, 32'd3, 5'd0);
        drain();

        send(4'd6, 32'd0, 32'd1, 5'd31);
        wait_valid(lat, nrdy);
        chk("sll31_latency", lat, 32);
        chk("sll31_busy_cycles", nrdy, 31);
        chk("sll31_result", ALUResult, 32'h8000_0000);
        @(posedge clk) #1;
        send(4'd5, 32'd0, 32'hF0, 5'd0);
        wait_valid(lat, nrdy);
        chk("srl0_latency", lat, 1);
        chk("srl0_result", ALUResult, 32'hF0);
        @(posedge clk) #1;

        send(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        c0 = cyc;
        send(4'd1, 32'hF000_0001, 32'h000F_0010, 5'd0);
        send(4'd7, 32'd0, 32'h0000_ABCD, 5'd0);
        send(4'd14, 32'h0040_0010, 32'd7, 5'd0);
        chk("b2b_cycles", cyc - c0, 3);
        drain();

        out_ready = 1'b0;
        send(4'd4, 32'd3, 32'd5, 5'd0);
        wait_valid(lat, nrdy);
        chk("sub_latency", lat, 1);
        repeat (4) begin
            @(negedge clk);
            chk("hold_result", {out_valid, in_ready, ALUResult}, {1'b1, 1'b0, 32'hFFFF_FFFE});
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        send(4'd15, 32'd9, 32'd9, 5'd0);
        wait_valid(lat, nrdy);
        chk("illegal", {Illegal, Zero, ALUResult}, {1'b1, 1'b1, 32'd0});
        @(posedge clk) #1;

        send(4'd6, 32'd0, 32'd3, 5'd10);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midshift_reset_outputs", {out_valid, ALUResult, Zero, BranchTaken, JumpReg, Illegal}, 64'd0);
        chk("midshift_reset_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        send(4'd3, 32'd2, 32'd3, 5'd0);
        wait_valid(lat, nrdy);
        chk("post_reset_add", {lat[7:0], ALUResult}, {8'd1, 32'd5});
        @(posedge clk) #1;

        rnd_en = 1'b1;
        repeat (300) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rs = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            send(op, ra, rb, rs);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk) #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        rnd_en = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
